ccip_mem_responder: RTL and testbench
=====================================

// Module: ccip_mem_responder
// PURPOSE
//  Synthesizable CCI-P host-memory responder: the FIU end of the link the smith_waterman requestor drives.
//  Accepts c0 read-line and c1 write-line requests.
//  Services them from an internal line RAM and returns c0/c1 responses with fixed latency and mdata echo.
//  Used in place of FIU+MPF for self-contained simulation and on-chip loopback of the requestor/core.
// PARAMETERS
//  MEM_LINES     1024  depth of line RAM in 64B lines (power of 2); address = hdr.address mod MEM_LINES
//  RD_LATENCY    8     cycles from read-request accept to c0.rspValid (>=2)
//  WR_LATENCY    4     cycles from write-request accept to c1.rspValid (>=2)
//  Q_DEPTH       16    entries in each of read and write pending queues (power of 2)
//  ALM_SLACK     4     almost-full asserted when queue occupancy >= Q_DEPTH-ALM_SLACK
// PORTS
//  clk           in   1             clock
//  reset_n       in   1             asynchronous, active-low reset
//  ccip_tx       in   t_if_ccip_Tx  requests from requestor; c0 = reads, c1 = writes, c2 ignored
//  ccip_rx       out  t_if_ccip_Rx  responses and almost-full to requestor
//  err_len       out  1             sticky: request with cl_len != eCL_LEN_1 seen
//  err_overflow  out  1             sticky: request arrived while its queue was full
//  rd_count      out  32            read requests accepted (wraps)
//  wr_count      out  32            write requests accepted (wraps)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all ccip_rx fields 0; err_* 0; counters 0; queues empty.
//   - RAM contents undefined, not cleared.
//  Accept, per channel:
//   - c0 request accepted when c0.valid && hdr.req_type==eREQ_RDLINE_*.
//   - c1 request accepted when c1.valid && hdr.req_type==eREQ_WRLINE_*.
//   - Other types ignored, no response.
//   - One request per channel per cycle; c0 and c1 may both be accepted in the same cycle.
//  Queue entry = {mdata, line index, timestamp}. Timestamp is a free-running 16-bit cycle counter captured at accept.
//  Read path:
//   - Head entry is released when (now - ts) == RD_LATENCY-1, mod 2^16.
//   - RAM is read on release (1-cycle RAM), so c0.rspValid occurs exactly RD_LATENCY cycles after accept.
//   - This holds when no backlog exists; with backlog, rspValid stays back-to-back, one per cycle, in accept order.
//   - c0.hdr: resp_type=eRSP_RDLINE, mdata echoed, cl_num=0, vc_used=eVC_VL0, hit_miss=0.
//   - c0.data = RAM line.
//  Write path:
//   - RAM written in the cycle after accept.
//   - c1.rspValid occurs WR_LATENCY cycles after accept, in order.
//   - c1.hdr: resp_type=eRSP_WRLINE, mdata echoed, format=0, cl_num=0.
//  Ordering:
//   - A read released in cycle N returns data including every write accepted before cycle N-1.
//   - Same-cycle write accept + read release to the same line returns OLD data.
//  Flow control:
//   - c0TxAlmFull = (rdq occupancy >= Q_DEPTH-ALM_SLACK); c1TxAlmFull likewise for wrq. Both registered.
//   - Request on a full queue: dropped, err_overflow set, count not incremented.
//  Multi-line (cl_len != 1):
//   - Treated as single line at the given address; err_len set.
//  Address wrap:
//   - Index = address[$clog2(MEM_LINES)-1:0]; upper bits ignored.
//  Unused outputs:
//   - c0.mmioRdValid and c0.mmioWrValid are held 0.
//  Reset mid-operation:
//   - In-flight requests are discarded; no responses are emitted after reset_n rises.
//  Timestamp wrap:
//   - Handled by modular subtraction; the queue bound guarantees age < 2^16.
// TESTING
//  1. Reset: hold reset_n=0 -> all rspValid=0, almfull=0, err_*=0, counts=0.
//  2. Write 0xA5.. to addr 5 (mdata 0x11), then read addr 5 (mdata 0x22).
//     -> c1.rspValid at +4 with mdata 0x11; c0.rspValid exactly 8 cycles after read accept, data 0xA5.., mdata 0x22.
//  3. Burst of 16 reads, one per cycle, ignoring almfull.
//     -> c0TxAlmFull rises after 12th accept; 16 responses in order, back-to-back.
//     -> 17th read sent while full: dropped, err_overflow=1, rd_count=16.
//  4. Same cycle: write addr 3 = X (prior content Y) and read release of addr 3 -> returns Y.
//     A read accepted 2 cycles after the write returns X.
//  5. Read addr MEM_LINES+7 after writing addr 7 -> same data returned.
//     Request with cl_len=eCL_LEN_2 -> single response, err_len=1.
//  6. Assert reset_n low with 5 reads in flight -> no c0.rspValid after release; rd_count=0.

Source files
------------

// File: rtl/ccip_mem_responder.sv
// ccip_mem_responder
//   Host-memory end of a CCI-P link, used in place of FIU+MPF. It services
//   c0 read-line and c1 write-line requests from an internal line RAM and
//   returns responses after a fixed latency, in order, echoing mdata.
//   The CCI-P header structs are flattened into plain ports.
// Ports
//   clk, reset_n                 clock, async active-low reset
//   c0_*_i                       read request (valid, req_type, cl_len, address, mdata)
//   c1_*_i                       write request (same fields plus 512-bit data)
//   c0_*_o                       read response, mmio strobes (held 0), c0TxAlmFull
//   c1_*_o                       write response, c1TxAlmFull
//   err_len / err_overflow       sticky error flags
//   rd_count / wr_count          accepted request counters (wrap)
module ccip_mem_responder #(
    parameter int MEM_LINES  = 1024,
    parameter int RD_LATENCY = 8,
    parameter int WR_LATENCY = 4,
    parameter int Q_DEPTH    = 16,
    parameter int ALM_SLACK  = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         c0_valid_i,
    input  logic [3:0]   c0_req_type_i,
    input  logic [1:0]   c0_cl_len_i,
    input  logic [41:0]  c0_address_i,
    input  logic [15:0]  c0_mdata_i,
    input  logic         c1_valid_i,
    input  logic [3:0]   c1_req_type_i,
    input  logic [1:0]   c1_cl_len_i,
    input  logic [41:0]  c1_address_i,
    input  logic [15:0]  c1_mdata_i,
    input  logic [511:0] c1_data_i,
    output logic         c0_rsp_valid_o,
    output logic [3:0]   c0_resp_type_o,
    output logic [15:0]  c0_mdata_o,
    output logic [1:0]   c0_cl_num_o,
    output logic [1:0]   c0_vc_used_o,
    output logic         c0_hit_miss_o,
    output logic [511:0] c0_data_o,
    output logic         c0_mmio_rd_valid_o,
    output logic         c0_mmio_wr_valid_o,
    output logic         c0_tx_alm_full_o,
    output logic         c1_rsp_valid_o,
    output logic [3:0]   c1_resp_type_o,
    output logic [15:0]  c1_mdata_o,
    output logic         c1_format_o,
    output logic [1:0]   c1_cl_num_o,
    output logic         c1_tx_alm_full_o,
    output logic         err_len,
    output logic         err_overflow,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
);
    localparam int IW = $clog2(MEM_LINES);
    localparam int QW = $clog2(Q_DEPTH);

    localparam logic [3:0]  REQ_RDLINE_I = 4'h0;
    localparam logic [3:0]  REQ_RDLINE_S = 4'h1;
    localparam logic [3:0]  REQ_WRLINE_I = 4'h0;
    localparam logic [3:0]  REQ_WRLINE_M = 4'h1;
    localparam logic [3:0]  RSP_RDLINE   = 4'h0;
    localparam logic [3:0]  RSP_WRLINE   = 4'h1;
    localparam logic [1:0]  CL_LEN_1     = 2'b00;
    localparam logic [1:0]  VC_VL0       = 2'b01;

    // Head is released once its age reaches LATENCY-1; the response
    // register adds the final cycle.
    localparam logic [15:0] RD_REL = 16'(RD_LATENCY - 1);
    localparam logic [15:0] WR_REL = 16'(WR_LATENCY - 1);
    localparam logic [QW:0] Q_FULL = (QW + 1)'(Q_DEPTH);
    localparam logic [QW:0] ALM_TH = (QW + 1)'(Q_DEPTH - ALM_SLACK);

    logic [15:0]   now_q;

    logic [15:0]   rdq_md_q  [Q_DEPTH];
    logic [IW-1:0] rdq_idx_q [Q_DEPTH];
    logic [15:0]   rdq_ts_q  [Q_DEPTH];
    logic [QW-1:0] rd_wp_q, rd_rp_q;
    logic [QW:0]   rd_cnt_q, rd_cnt_d;
    logic          rd_req, rd_push, rd_pop;
    logic [15:0]   rd_age;

    logic [15:0]   wrq_md_q [Q_DEPTH];
    logic [15:0]   wrq_ts_q [Q_DEPTH];
    logic [QW-1:0] wr_wp_q, wr_rp_q;
    logic [QW:0]   wr_cnt_q, wr_cnt_d;
    logic          wr_req, wr_push, wr_pop;
    logic [15:0]   wr_age;

    // Accepted write data lands in the RAM one cycle after accept.
    logic          wr_pend_q;
    logic [IW-1:0] wr_pend_idx_q;
    logic [511:0]  wr_pend_data_q;
    logic [511:0]  mem_q [MEM_LINES];

    logic          c0_vld_q, c0_alm_q, c1_vld_q, c1_alm_q;
    logic [15:0]   c0_md_q, c1_md_q;
    logic [1:0]    c0_vc_q;
    logic [3:0]    c1_rtype_q;
    logic [511:0]  c0_data_q;
    logic          err_len_q, err_ovf_q;
    logic [31:0]   rd_count_q, wr_count_q;

    logic          unused_addr_bits;
    assign unused_addr_bits = ^{c0_address_i[41:IW], c1_address_i[41:IW]};

    always_comb begin
        rd_req   = c0_valid_i && (c0_req_type_i == REQ_RDLINE_I || c0_req_type_i == REQ_RDLINE_S);
        wr_req   = c1_valid_i && (c1_req_type_i == REQ_WRLINE_I || c1_req_type_i == REQ_WRLINE_M);
        rd_push  = rd_req && (rd_cnt_q != Q_FULL);
        wr_push  = wr_req && (wr_cnt_q != Q_FULL);
        // Modular age; >= keeps backlogged entries draining one per cycle.
        rd_age   = now_q - rdq_ts_q[rd_rp_q];
        wr_age   = now_q - wrq_ts_q[wr_rp_q];
        rd_pop   = (rd_cnt_q != '0) && (rd_age >= RD_REL);
        wr_pop   = (wr_cnt_q != '0) && (wr_age >= WR_REL);
        rd_cnt_d = rd_cnt_q + (QW + 1)'(rd_push) - (QW + 1)'(rd_pop);
        wr_cnt_d = wr_cnt_q + (QW + 1)'(wr_push) - (QW + 1)'(wr_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            now_q      <= '0;
            rd_wp_q    <= '0;
            rd_rp_q    <= '0;
            rd_cnt_q   <= '0;
            wr_wp_q    <= '0;
            wr_rp_q    <= '0;
            wr_cnt_q   <= '0;
            wr_pend_q  <= 1'b0;
            c0_vld_q   <= 1'b0;
            c0_alm_q   <= 1'b0;
            c0_md_q    <= '0;
            c0_vc_q    <= '0;
            c0_data_q  <= '0;
            c1_vld_q   <= 1'b0;
            c1_alm_q   <= 1'b0;
            c1_md_q    <= '0;
            c1_rtype_q <= '0;
            err_len_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            now_q     <= now_q + 16'd1;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            c0_alm_q  <= (rd_cnt_d >= ALM_TH);
            c1_alm_q  <= (wr_cnt_d >= ALM_TH);
            wr_pend_q <= wr_push;
            if (rd_push) rd_wp_q <= rd_wp_q + QW'(1);
            if (rd_pop)  rd_rp_q <= rd_rp_q + QW'(1);
            if (wr_push) wr_wp_q <= wr_wp_q + QW'(1);
            if (wr_pop)  wr_rp_q <= wr_rp_q + QW'(1);

            // RAM read happens here, before this edge's pending write lands,
            // so a write accepted in the release cycle is not visible.
            c0_vld_q <= rd_pop;
            c0_vc_q  <= rd_pop ? VC_VL0 : 2'b00;
            if (rd_pop) begin
                c0_md_q   <= rdq_md_q[rd_rp_q];
                c0_data_q <= mem_q[rdq_idx_q[rd_rp_q]];
            end
            c1_vld_q   <= wr_pop;
            c1_rtype_q <= wr_pop ? RSP_WRLINE : 4'h0;
            if (wr_pop) c1_md_q <= wrq_md_q[wr_rp_q];

            if ((rd_req && c0_cl_len_i != CL_LEN_1) || (wr_req && c1_cl_len_i != CL_LEN_1))
                err_len_q <= 1'b1;
            if ((rd_req && !rd_push) || (wr_req && !wr_push))
                err_ovf_q <= 1'b1;
            if (rd_push) rd_count_q <= rd_count_q + 32'd1;
            if (wr_push) wr_count_q <= wr_count_q + 32'd1;
        end
    end

    // Storage without reset: queue payloads and the line RAM.
    always_ff @(posedge clk) begin
        if (rd_push) begin
            rdq_md_q[rd_wp_q]  <= c0_mdata_i;
            rdq_idx_q[rd_wp_q] <= c0_address_i[IW-1:0];
            rdq_ts_q[rd_wp_q]  <= now_q;
        end
        if (wr_push) begin
            wrq_md_q[wr_wp_q] <= c1_mdata_i;
            wrq_ts_q[wr_wp_q] <= now_q;
            wr_pend_idx_q     <= c1_address_i[IW-1:0];
            wr_pend_data_q    <= c1_data_i;
        end
        if (wr_pend_q) mem_q[wr_pend_idx_q] <= wr_pend_data_q;
    end

    assign c0_rsp_valid_o     = c0_vld_q;
    assign c0_resp_type_o     = RSP_RDLINE;
    assign c0_mdata_o         = c0_md_q;
    assign c0_cl_num_o        = 2'b00;
    assign c0_vc_used_o       = c0_vc_q;
    assign c0_hit_miss_o      = 1'b0;
    assign c0_data_o          = c0_data_q;
    assign c0_mmio_rd_valid_o = 1'b0;
    assign c0_mmio_wr_valid_o = 1'b0;
    assign c0_tx_alm_full_o   = c0_alm_q;
    assign c1_rsp_valid_o     = c1_vld_q;
    assign c1_resp_type_o     = c1_rtype_q;
    assign c1_mdata_o         = c1_md_q;
    assign c1_format_o        = 1'b0;
    assign c1_cl_num_o        = 2'b00;
    assign c1_tx_alm_full_o   = c1_alm_q;
    assign err_len            = err_len_q;
    assign err_overflow       = err_ovf_q;
    assign rd_count           = rd_count_q;
    assign wr_count           = wr_count_q;
endmodule

// File: tb/tb_ccip_mem_responder.sv
// Directed bench for ccip_mem_responder. u_dut uses default parameters;
// u_deep shares the same stimulus with RD_LATENCY=24 so a one-per-cycle read
// burst can actually fill the 16-entry read queue.
module tb_ccip_mem_responder;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         c0_valid, c1_valid;
    logic [3:0]   c0_req_type, c1_req_type;
    logic [1:0]   c0_cl_len, c1_cl_len;
    logic [41:0]  c0_address, c1_address;
    logic [15:0]  c0_mdata, c1_mdata;
    logic [511:0] c1_data;

    logic         c0_rsp_valid, c0_hit_miss, c0_mmio_rd, c0_mmio_wr, c0_alm;
    logic [3:0]   c0_resp_type;
    logic [15:0]  c0_mdata_o;
    logic [1:0]   c0_cl_num, c0_vc_used;
    logic [511:0] c0_data;
    logic         c1_rsp_valid, c1_format, c1_alm;
    logic [3:0]   c1_resp_type;
    logic [15:0]  c1_mdata_o;
    logic [1:0]   c1_cl_num;
    logic         err_len, err_overflow;
    logic [31:0]  rd_count, wr_count;

    logic         d_c0_rsp_valid, d_c0_hit_miss, d_c0_mmio_rd, d_c0_mmio_wr, d_c0_alm;
    logic [3:0]   d_c0_resp_type;
    logic [15:0]  d_c0_mdata_o;
    logic [1:0]   d_c0_cl_num, d_c0_vc_used;
    logic [511:0] d_c0_data;
    logic         d_c1_rsp_valid, d_c1_format, d_c1_alm;
    logic [3:0]   d_c1_resp_type;
    logic [15:0]  d_c1_mdata_o;
    logic [1:0]   d_c1_cl_num;
    logic         d_err_len, d_err_overflow;
    logic [31:0]  d_rd_count, d_wr_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ccip_mem_responder u_dut (
        .clk(clk), .reset_n(reset_n),
        .c0_valid_i(c0_valid), .c0_req_type_i(c0_req_type), .c0_cl_len_i(c0_cl_len),
        .c0_address_i(c0_address), .c0_mdata_i(c0_mdata),
        .c1_valid_i(c1_valid), .c1_req_type_i(c1_req_type), .c1_cl_len_i(c1_cl_len),
        .c1_address_i(c1_address), .c1_mdata_i(c1_mdata), .c1_data_i(c1_data),
        .c0_rsp_valid_o(c0_rsp_valid), .c0_resp_type_o(c0_resp_type), .c0_mdata_o(c0_mdata_o),
        .c0_cl_num_o(c0_cl_num), .c0_vc_used_o(c0_vc_used), .c0_hit_miss_o(c0_hit_miss),
        .c0_data_o(c0_data), .c0_mmio_rd_valid_o(c0_mmio_rd), .c0_mmio_wr_valid_o(c0_mmio_wr),
        .c0_tx_alm_full_o(c0_alm),
        .c1_rsp_valid_o(c1_rsp_valid), .c1_resp_type_o(c1_resp_type), .c1_mdata_o(c1_mdata_o),
        .c1_format_o(c1_format), .c1_cl_num_o(c1_cl_num), .c1_tx_alm_full_o(c1_alm),
        .err_len(err_len), .err_overflow(err_overflow), .rd_count(rd_count), .wr_count(wr_count)
    );

    ccip_mem_responder #(.RD_LATENCY(24)) u_deep (
        .clk(clk), .reset_n(reset_n),
        .c0_valid_i(c0_valid), .c0_req_type_i(c0_req_type), .c0_cl_len_i(c0_cl_len),
        .c0_address_i(c0_address), .c0_mdata_i(c0_mdata),
        .c1_valid_i(c1_valid), .c1_req_type_i(c1_req_type), .c1_cl_len_i(c1_cl_len),
        .c1_address_i(c1_address), .c1_mdata_i(c1_mdata), .c1_data_i(c1_data),
        .c0_rsp_valid_o(d_c0_rsp_valid), .c0_resp_type_o(d_c0_resp_type), .c0_mdata_o(d_c0_mdata_o),
        .c0_cl_num_o(d_c0_cl_num), .c0_vc_used_o(d_c0_vc_used), .c0_hit_miss_o(d_c0_hit_miss),
        .c0_data_o(d_c0_data), .c0_mmio_rd_valid_o(d_c0_mmio_rd), .c0_mmio_wr_valid_o(d_c0_mmio_wr),
        .c0_tx_alm_full_o(d_c0_alm),
        .c1_rsp_valid_o(d_c1_rsp_valid), .c1_resp_type_o(d_c1_resp_type), .c1_mdata_o(d_c1_mdata_o),
        .c1_format_o(d_c1_format), .c1_cl_num_o(d_c1_cl_num), .c1_tx_alm_full_o(d_c1_alm),
        .err_len(d_err_len), .err_overflow(d_err_overflow), .rd_count(d_rd_count), .wr_count(d_wr_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request is presented in the current cycle and accepted at the next edge.
    task automatic send_rd(input logic [41:0] a, input logic [15:0] md, input logic [1:0] len);
        c0_valid = 1'b1; c0_req_type = 4'h0; c0_address = a; c0_mdata = md; c0_cl_len = len;
        tick();
        c0_valid = 1'b0;
    endtask

    task automatic send_wr(input logic [41:0] a, input logic [15:0] md, input logic [511:0] d);
        c1_valid = 1'b1; c1_req_type = 4'h0; c1_address = a; c1_mdata = md; c1_cl_len = 2'b00; c1_data = d;
        tick();
        c1_valid = 1'b0;
    endtask

    // n = number of edges since the request was presented (accept edge = 1).
    task automatic wait_c0(output int n);
        n = 1;
        while (c0_rsp_valid !== 1'b1 && n < 60) begin tick(); n++; end
    endtask

    task automatic wait_c1(output int n);
        n = 1;
        while (c1_rsp_valid !== 1'b1 && n < 60) begin tick(); n++; end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        c0_valid = 1'b1; c0_req_type = 4'h0; c1_valid = 1'b1; c1_req_type = 4'h0;
        repeat (3) tick();
        checks++; if (c0_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_c0_valid got=%b exp=0", c0_rsp_valid); end
        checks++; if (c1_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_c1_valid got=%b exp=0", c1_rsp_valid); end
        checks++; if ({c0_alm, c1_alm} !== 2'b00) begin failures++; $display("FAIL reset_almfull got=%b exp=00", {c0_alm, c1_alm}); end
        checks++; if ({err_len, err_overflow} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", {err_len, err_overflow}); end
        checks++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", rd_count, wr_count); end
        checks++; if (c0_data !== 512'd0 || c0_vc_used !== 2'b00 || c0_mdata_o !== 16'd0) begin failures++; $display("FAIL reset_c0_fields vc=%b md=%h exp=0", c0_vc_used, c0_mdata_o); end
        checks++; if ({c0_mmio_rd, c0_mmio_wr} !== 2'b00) begin failures++; $display("FAIL reset_mmio got=%b exp=00", {c0_mmio_rd, c0_mmio_wr}); end
        c0_valid = 1'b0; c1_valid = 1'b0;
        reset_n = 1'b1;
        repeat (2) tick();
        checks++; if (rd_count !== 32'd0 || c0_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_release rd_count=%0d valid=%b exp=0/0", rd_count, c0_rsp_valid); end
    endtask

    task automatic test_write_read();
        int n;
        send_wr(42'd5, 16'h0011, {64{8'hA5}});
        wait_c1(n);
        checks++; if (n != 4) begin failures++; $display("FAIL wr_latency got=%0d exp=4", n); end
        checks++; if (c1_mdata_o !== 16'h0011 || c1_resp_type !== 4'h1) begin failures++; $display("FAIL wr_rsp_hdr md=%h type=%h exp=0011/1", c1_mdata_o, c1_resp_type); end
        tick();
        checks++; if (c1_rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_rsp_single got=%b exp=0", c1_rsp_valid); end
        send_rd(42'd5, 16'h0022, 2'b00);
        wait_c0(n);
        checks++; if (n != 8) begin failures++; $display("FAIL rd_latency got=%0d exp=8", n); end
        checks++; if (c0_data !== {64{8'hA5}}) begin failures++; $display("FAIL rd_data got=%h exp=a5..", c0_data); end
        checks++; if (c0_mdata_o !== 16'h0022 || c0_resp_type !== 4'h0 || c0_vc_used !== 2'b01) begin failures++; $display("FAIL rd_rsp_hdr md=%h type=%h vc=%b exp=0022/0/01", c0_mdata_o, c0_resp_type, c0_vc_used); end
        tick();
        checks++; if (c0_rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_rsp_single got=%b exp=0", c0_rsp_valid); end
        checks++; if (rd_count !== 32'd1 || wr_count !== 32'd1) begin failures++; $display("FAIL counts_wr_rd got=%0d/%0d exp=1/1", rd_count, wr_count); end
    endtask

    task automatic test_same_cycle();
        int n;
        logic [511:0] x_line, y_line;
        x_line = {64{8'h3C}};
        y_line = {64{8'hC3}};
        send_wr(42'd3, 16'h0030, y_line);
        repeat (6) tick();
        send_rd(42'd3, 16'h0031, 2'b00);   // accepted cycle A
        repeat (6) tick();                 // now in cycle A+7: release cycle
        send_wr(42'd3, 16'h0032, x_line);  // write accepted in the release cycle
        checks++; if (c0_rsp_valid !== 1'b1 || c0_mdata_o !== 16'h0031) begin failures++; $display("FAIL same_cycle_rsp valid=%b md=%h exp=1/0031", c0_rsp_valid, c0_mdata_o); end
        checks++; if (c0_data !== y_line) begin failures++; $display("FAIL same_cycle_old got=%h exp=c3..", c0_data); end
        tick();                            // two cycles after the write accept
        send_rd(42'd3, 16'h0033, 2'b00);
        wait_c0(n);
        checks++; if (n != 8 || c0_data !== x_line || c0_mdata_o !== 16'h0033) begin failures++; $display("FAIL after_write_new n=%0d md=%h data=%h exp=8/0033/3c..", n, c0_mdata_o, c0_data); end
    endtask

    task automatic test_wrap_len();
        int n;
        int extra;
        logic [511:0] z_line;
        z_line = {16{32'hDEAD_0007}};
        send_wr(42'd7, 16'h0070, z_line);
        repeat (3) tick();
        send_rd(42'd1031, 16'h0071, 2'b00);
        wait_c0(n);
        checks++; if (n != 8 || c0_data !== z_line || c0_mdata_o !== 16'h0071) begin failures++; $display("FAIL addr_wrap n=%0d md=%h data=%h", n, c0_mdata_o, c0_data); end
        checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL err_len_early got=%b exp=0", err_len); end
        send_rd(42'd7, 16'h0072, 2'b01);
        wait_c0(n);
        checks++; if (n != 8 || c0_data !== z_line || c0_mdata_o !== 16'h0072) begin failures++; $display("FAIL multi_line_rsp n=%0d md=%h", n, c0_mdata_o); end
        extra = 0;
        repeat (12) begin tick(); if (c0_rsp_valid === 1'b1) extra++; end
        checks++; if (extra != 0) begin failures++; $display("FAIL multi_line_single extra=%0d exp=0", extra); end
        checks++; if (err_len !== 1'b1) begin failures++; $display("FAIL err_len got=%b exp=1", err_len); end
    endtask

    task automatic test_ignored();
        int seen;
        logic [31:0] rd_base, wr_base;
        rd_base = rd_count;
        wr_base = wr_count;
        c0_valid = 1'b1; c0_req_type = 4'h4; c0_cl_len = 2'b00;
        c1_valid = 1'b1; c1_req_type = 4'h4; c1_cl_len = 2'b00;
        tick();
        c0_valid = 1'b0; c1_valid = 1'b0;
        seen = 0;
        repeat (12) begin tick(); if (c0_rsp_valid === 1'b1 || c1_rsp_valid === 1'b1) seen++; end
        checks++; if (seen != 0) begin failures++; $display("FAIL ignored_type_rsp got=%0d exp=0", seen); end
        checks++; if (rd_count !== rd_base || wr_count !== wr_base) begin failures++; $display("FAIL ignored_type_count got=%0d/%0d exp=%0d/%0d", rd_count, wr_count, rd_base, wr_base); end
    endtask

    task automatic test_burst();
        int got, gaps, order_bad, first, last;
        logic [31:0] base;
        repeat (40) tick();
        base = d_rd_count;
        for (int k = 0; k < 17; k++) begin
            c0_valid = 1'b1; c0_req_type = 4'h1; c0_cl_len = 2'b00;
            c0_address = 42'(k); c0_mdata = 16'h0100 + 16'(k);
            tick();
            if (k == 10) begin checks++; if (d_c0_alm !== 1'b0) begin failures++; $display("FAIL almfull_11 got=%b exp=0", d_c0_alm); end end
            if (k == 11) begin checks++; if (d_c0_alm !== 1'b1) begin failures++; $display("FAIL almfull_12 got=%b exp=1", d_c0_alm); end end
        end
        c0_valid = 1'b0;
        checks++; if (d_err_overflow !== 1'b1) begin failures++; $display("FAIL overflow_flag got=%b exp=1", d_err_overflow); end
        checks++; if (d_rd_count - base !== 32'd16) begin failures++; $display("FAIL overflow_count got=%0d exp=16", d_rd_count - base); end
        checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL shallow_no_overflow got=%b exp=0", err_overflow); end
        got = 0; gaps = 0; order_bad = 0; first = -1; last = -1;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (d_c0_rsp_valid === 1'b1) begin
                if (got == 0) first = t;
                else if (t != last + 1) gaps++;
                if (d_c0_mdata_o !== 16'h0100 + 16'(got)) order_bad++;
                got++;
                last = t;
            end
        end
        checks++; if (got != 16) begin failures++; $display("FAIL burst_count got=%0d exp=16", got); end
        checks++; if (gaps != 0 || order_bad != 0) begin failures++; $display("FAIL burst_order gaps=%0d misordered=%0d exp=0/0", gaps, order_bad); end
        // First read presented 17 edges before this loop; response 24 edges after presentation.
        checks++; if (first != 6) begin failures++; $display("FAIL burst_first_latency got=%0d exp=6", first); end
    endtask

    task automatic test_reset_mid();
        int seen;
        for (int k = 0; k < 5; k++) send_rd(42'(20 + k), 16'h0050 + 16'(k), 2'b00);
        repeat (2) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        seen = 0;
        repeat (20) begin tick(); if (c0_rsp_valid === 1'b1) seen++; end
        checks++; if (seen != 0) begin failures++; $display("FAIL reset_mid_rsp got=%0d exp=0", seen); end
        checks++; if (rd_count !== 32'd0) begin failures++; $display("FAIL reset_mid_count got=%0d exp=0", rd_count); end
        checks++; if (err_len !== 1'b0 || d_err_overflow !== 1'b0) begin failures++; $display("FAIL reset_mid_err got=%b%b exp=00", err_len, d_err_overflow); end
    endtask

    initial begin
        c0_valid = 1'b0; c0_req_type = 4'h0; c0_cl_len = 2'b00; c0_address = '0; c0_mdata = '0;
        c1_valid = 1'b0; c1_req_type = 4'h0; c1_cl_len = 2'b00; c1_address = '0; c1_mdata = '0; c1_data = '0;
        test_reset();
        test_write_read();
        test_same_cycle();
        test_wrap_len();
        test_ignored();
        test_burst();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
